svm_det_collector: RTL and testbench
====================================

Name: svm_det_collector

Overview:
- Sits directly downstream of the HOG+SVM classifier top and consumes its per-slide-window output: valid strobe, is_person, signed score and slide-window index.
- Keeps detections whose score is at or above a programmable threshold in a FIFO, which the host drains over a valid/ready interface.
- Also produces per-frame summary results: qualified-detection count, best-scoring window and sticky overflow.

Parameters:
- FEA_W, 16, score width (signed two's complement, Q4.12).
- SW_W, 11, slide-window index width.
- N_SW, 1200, slide windows per frame; index N_SW-1 closes a frame.
- DEPTH, 16, FIFO entries (power of two).
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  classifier result strobe, one cycle per window.
- is_person  in  1  classifier decision.
- result  in  FEA_W  signed classifier score.
- sw_id  in  SW_W  window index.
- thresh  in  FEA_W  signed storage threshold, sampled each cycle.
- o_valid  out  1  FIFO head valid.
- ready  in  1  host accepts head.
- o_sw_id  out  SW_W  head window index.
- o_score  out  FEA_W  head score.
- level  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- frame_done  out  1  one-cycle pulse after the last window of a frame.
- frame_cnt  out  SW_W  qualified detections in the closed frame.
- best_valid  out  1  closed frame had at least one is_person window.
- best_id  out  SW_W  index of the highest-scoring is_person window.
- best_score  out  FEA_W  that window's score.
- overflow  out  1  sticky: a qualified detection was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty; o_valid=0, level=0; o_sw_id and o_score=0; frame_done=0, frame_cnt=0, best_valid=0, best_id=0, best_score=0, overflow=0; per-frame accumulators cleared.
- Reset mid-frame discards the partial frame and all FIFO contents.
- Window accepted: i_valid=1 and sw_id < N_SW. Windows with sw_id >= N_SW are ignored entirely.
- Qualified: accepted, is_person=1 and $signed(result) >= $signed(thresh). Comparison is full-width signed.
- FIFO is first-word fall-through:
  - Push: a qualified window writes {sw_id, result}.
  - Pop: a cycle with o_valid && ready.
  - o_valid is the registered !empty. The first push into an empty FIFO gives o_valid=1 on the next cycle; o_sw_id/o_score always show the head entry.
  - level updates one cycle after the push/pop. Simultaneous push and pop leave level unchanged.
- Full (level==DEPTH):
  - Push without pop: entry dropped, overflow set next cycle.
  - Push with simultaneous pop: accepted, no drop.
- Empty: ready is ignored; pointers do not move.
- Pointers wrap modulo DEPTH.
- overflow is sticky until an ovf_clr cycle. If ovf_clr and a drop occur in the same cycle, set wins.
- Per-frame accumulators:
  - acc_cnt: qualified windows, saturating at 2^SW_W-1; counts every qualified window, including dropped ones.
  - acc_best: max score over accepted is_person windows, ignoring thresh; on a tie the earlier window is kept; acc_best_valid marks that at least one has been seen.
- Frame close: an accepted window with sw_id == N_SW-1.
  - On the next cycle frame_done=1 for exactly one cycle.
  - frame_cnt, best_valid, best_id and best_score load values that include the closing window.
  - Accumulators restart at zero/empty in that same cycle.
  - Summary outputs hold until the next close.
- Out-of-order or missing indices are not checked: frames are delimited only by N_SW-1.
- Back-to-back i_valid every cycle is supported: no stalls, no backpressure to the classifier; the FIFO is the only loss point.

Test Plan:
- Reset, then thresh=0x0000; drive sw_id=5, is_person=1, result=0x0800 -> o_valid=1 one cycle later, o_sw_id=5, o_score=0x0800, level=1. Pulse ready -> o_valid=0, level=0.
- thresh=0x1000; windows with scores 0x0FFF, 0x1000 and 0xF000 (negative), all is_person=1 -> only 0x1000 stored, level=1.
- ready=0; 17 qualified windows ids 0..16 -> level=16, overflow=1, head id 0. Drain with ready=1 -> ids 0..15 in order, id 16 absent. ovf_clr -> overflow=0.
- level=16 with a push and pop in the same cycle -> level stays 16, overflow stays 0, new entry appears at the tail.
- Frame with N_SW=1200: is_person windows id 3 (0x0400), 700 (0x2000), 900 (0x2000), thresh=0x1000, then id 1199 is_person=0 -> one cycle after id 1199, frame_done=1 for one cycle, frame_cnt=2, best_valid=1, best_id=700, best_score=0x2000. Next frame with no person windows -> frame_cnt=0, best_valid=0.
- Drop rst low mid-frame with level=3 -> all outputs 0 asynchronously. After release, the partial frame is discarded: the next close reports only post-reset windows.

Source files
------------

// File: rtl/svm_det_collector.sv
// svm_det_collector: threshold-filtered detection FIFO plus per-frame summary behind the HOG+SVM classifier
// Ports: classifier side i_valid/is_person/result/sw_id, storage threshold thresh;
//        host FWFT side o_valid/ready/o_sw_id/o_score/level; frame summary frame_done/frame_cnt/best_*;
//        sticky overflow with ovf_clr. rst is asynchronous active-low.
module svm_det_collector #(
  parameter int FEA_W  = 16,
  parameter int SW_W   = 11,
  parameter int N_SW   = 1200,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              is_person,
  input  logic [FEA_W-1:0]  result,
  input  logic [SW_W-1:0]   sw_id,
  input  logic [FEA_W-1:0]  thresh,
  output logic              o_valid,
  input  logic              ready,
  output logic [SW_W-1:0]   o_sw_id,
  output logic [FEA_W-1:0]  o_score,
  output logic [ADDR_W:0]   level,
  output logic              frame_done,
  output logic [SW_W-1:0]   frame_cnt,
  output logic              best_valid,
  output logic [SW_W-1:0]   best_id,
  output logic [FEA_W-1:0]  best_score,
  output logic              overflow,
  input  logic              ovf_clr
);
  localparam logic [SW_W-1:0] LAST = SW_W'(N_SW - 1);
  logic [SW_W+FEA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [ADDR_W:0] level_q, level_d;
  logic o_valid_q, ovf_q;
  logic accept, qual, close, pop, full, push, drop, upd;
  logic [SW_W-1:0] acc_cnt_q, acc_cnt_d, acc_bid_q, acc_bid_d;
  logic [FEA_W-1:0] acc_bs_q, acc_bs_d;
  logic acc_bv_q, acc_bv_d;
  logic fd_q, bv_q;
  logic [SW_W-1:0] fc_q, bid_q;
  logic [FEA_W-1:0] bs_q;
  assign accept = i_valid && sw_id <= LAST;
  assign qual = accept && is_person && ($signed(result) >= $signed(thresh));
  assign close = accept && sw_id == LAST;
  assign pop = o_valid_q && ready;
  assign full = level_q == (ADDR_W+1)'(DEPTH);
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push = qual && (!full || pop);
  assign drop = qual && full && !pop;
  assign level_d = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  always_comb begin
    acc_cnt_d = (qual && acc_cnt_q != '1) ? acc_cnt_q + SW_W'(1) : acc_cnt_q;
    // strict greater-than keeps the earlier window on a tie
    upd = accept && is_person && (!acc_bv_q || $signed(result) > $signed(acc_bs_q));
    acc_bv_d = acc_bv_q || (accept && is_person);
    acc_bid_d = upd ? sw_id : acc_bid_q;
    acc_bs_d = upd ? result : acc_bs_q;
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= {sw_id, result};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      o_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      acc_cnt_q <= '0;
      acc_bv_q <= 1'b0;
      acc_bid_q <= '0;
      acc_bs_q <= '0;
      fd_q <= 1'b0;
      fc_q <= '0;
      bv_q <= 1'b0;
      bid_q <= '0;
      bs_q <= '0;
    end else begin
      wr_q <= wr_q + ADDR_W'(push);
      rd_q <= rd_q + ADDR_W'(pop);
      level_q <= level_d;
      o_valid_q <= level_d != '0;
      ovf_q <= drop || (ovf_q && !ovf_clr);
      fd_q <= close;
      acc_cnt_q <= close ? '0 : acc_cnt_d;
      acc_bv_q <= close ? 1'b0 : acc_bv_d;
      acc_bid_q <= close ? '0 : acc_bid_d;
      acc_bs_q <= close ? '0 : acc_bs_d;
      if (close) begin
        fc_q <= acc_cnt_d;
        bv_q <= acc_bv_d;
        bid_q <= acc_bid_d;
        bs_q <= acc_bs_d;
      end
    end
  end
  // head is forced to zero while empty so reset and drained states read as zero
  assign o_valid = o_valid_q;
  assign o_sw_id = o_valid_q ? mem_q[rd_q][FEA_W +: SW_W] : '0;
  assign o_score = o_valid_q ? mem_q[rd_q][FEA_W-1:0] : '0;
  assign level = level_q;
  assign overflow = ovf_q;
  assign frame_done = fd_q;
  assign frame_cnt = fc_q;
  assign best_valid = bv_q;
  assign best_id = bid_q;
  assign best_score = bs_q;
endmodule

// File: tb/tb_svm_det_collector.sv
// tb_svm_det_collector: scoreboard bench for svm_det_collector
module tb_svm_det_collector;
  logic clk = 1'b0, rst = 1'b0, i_valid = 1'b0, is_person = 1'b0, ready = 1'b0, ovf_clr = 1'b0;
  logic [15:0] result = '0, thresh = '0;
  logic [10:0] sw_id = '0;
  logic o_valid, frame_done, best_valid, overflow;
  logic [10:0] o_sw_id, frame_cnt, best_id;
  logic [15:0] o_score, best_score;
  logic [4:0] level;
  int n_tests = 0, n_fail = 0;
  typedef struct packed {logic [10:0] id; logic [15:0] sc;} ent_t;
  ent_t exp_q[$];
  int m_cnt;
  bit m_bv, m_fd, m_ovf, e_bv;
  logic [10:0] m_bid, e_fc, e_bid;
  logic [15:0] m_bs, e_bs;
  svm_det_collector dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .is_person(is_person), .result(result),
    .sw_id(sw_id), .thresh(thresh), .o_valid(o_valid), .ready(ready), .o_sw_id(o_sw_id),
    .o_score(o_score), .level(level), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .best_valid(best_valid), .best_id(best_id), .best_score(best_score),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_model;
    exp_q.delete();
    m_cnt = 0; m_bv = 0; m_bid = '0; m_bs = '0; m_fd = 0; m_ovf = 0;
    e_fc = '0; e_bv = 0; e_bid = '0; e_bs = '0;
  endtask
  task automatic cyc(input bit v, input bit p, input logic [15:0] res, input logic [10:0] id,
                     input bit r, input bit clr);
    bit acc, q, drop;
    ent_t h;
    i_valid = v; is_person = p; result = res; sw_id = id; ready = r; ovf_clr = clr;
    acc = v && id < 11'd1200;
    q = acc && p && ($signed(res) >= $signed(thresh));
    drop = 0;
    if (r && exp_q.size() > 0) begin
      h = exp_q.pop_front();
      chk("pop_id", o_sw_id, h.id);
      chk("pop_score", o_score, h.sc);
    end
    if (q) begin
      h = {id, res};
      if (exp_q.size() < 16) exp_q.push_back(h);
      else drop = 1;
    end
    m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
    if (q && m_cnt < 2047) m_cnt++;
    if (acc && p && (!m_bv || $signed(res) > $signed(m_bs))) begin
      m_bv = 1; m_bid = id; m_bs = res;
    end
    m_fd = acc && id == 11'd1199;
    if (m_fd) begin
      e_fc = 11'(m_cnt); e_bv = m_bv; e_bid = m_bid; e_bs = m_bs;
      m_cnt = 0; m_bv = 0; m_bid = '0; m_bs = '0;
    end
    tick;
    i_valid = 0; is_person = 0; ready = 0; ovf_clr = 0;
    chk("level", level, exp_q.size());
    chk("o_valid", o_valid, exp_q.size() != 0);
    chk("overflow", overflow, m_ovf);
    chk("frame_done", frame_done, m_fd);
    chk("frame_cnt", frame_cnt, e_fc);
    chk("best_valid", best_valid, e_bv);
    chk("best_id", best_id, e_bid);
    chk("best_score", best_score, e_bs);
    if (exp_q.size() > 0) begin
      chk("head_id", o_sw_id, exp_q[0].id);
      chk("head_score", o_score, exp_q[0].sc);
    end
  endtask
  task automatic idle(input bit r);
    cyc(0, 0, '0, '0, r, 0);
  endtask
  initial begin
    reset_model();
    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_o_sw_id", o_sw_id, 0);
    chk("rst_o_score", o_score, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_best_valid", best_valid, 0);
    @(posedge clk);
    #1 rst = 1;
    thresh = 16'h0000;
    cyc(1, 1, 16'h0800, 11'd5, 0, 0);
    chk("t1_o_valid", o_valid, 1);
    chk("t1_o_sw_id", o_sw_id, 5);
    chk("t1_o_score", o_score, 16'h0800);
    chk("t1_level", level, 1);
    idle(1);
    chk("t1_drain_o_valid", o_valid, 0);
    chk("t1_drain_level", level, 0);
    thresh = 16'h1000;
    cyc(1, 1, 16'h0FFF, 11'd1, 0, 0);
    cyc(1, 1, 16'h1000, 11'd2, 0, 0);
    cyc(1, 1, 16'hF000, 11'd3, 0, 0);
    chk("t2_level", level, 1);
    chk("t2_score", o_score, 16'h1000);
    idle(1);
    cyc(1, 1, 16'h7FFF, 11'd1200, 0, 0);
    chk("ignored_level", level, 0);
    for (int i = 0; i < 17; i++) cyc(1, 1, 16'h1000 + 16'(i), 11'(i), 0, 0);
    chk("t3_level", level, 16);
    chk("t3_overflow", overflow, 1);
    chk("t3_head", o_sw_id, 0);
    for (int i = 0; i < 16; i++) idle(1);
    chk("t3_empty", level, 0);
    chk("t3_ovf_sticky", overflow, 1);
    cyc(0, 0, '0, '0, 0, 1);
    chk("t3_ovf_clr", overflow, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 16'h2000, 11'(20 + i), 0, 0);
    cyc(1, 1, 16'h1234, 11'd36, 1, 0);
    chk("t4_level", level, 16);
    chk("t4_overflow", overflow, 0);
    for (int i = 0; i < 16; i++) idle(1);
    chk("t4_empty", level, 0);
    cyc(1, 0, '0, 11'd1199, 0, 0);
    idle(0);
    cyc(1, 1, 16'h0400, 11'd3, 1, 0);
    cyc(1, 1, 16'h2000, 11'd700, 1, 0);
    cyc(1, 1, 16'h2000, 11'd900, 1, 0);
    cyc(1, 0, 16'h0000, 11'd1199, 1, 0);
    chk("t5_frame_done", frame_done, 1);
    chk("t5_frame_cnt", frame_cnt, 2);
    chk("t5_best_valid", best_valid, 1);
    chk("t5_best_id", best_id, 700);
    chk("t5_best_score", best_score, 16'h2000);
    idle(1);
    chk("t5_pulse_end", frame_done, 0);
    chk("t5_hold_id", best_id, 700);
    cyc(1, 0, 16'h7000, 11'd1199, 1, 0);
    chk("t5b_frame_cnt", frame_cnt, 0);
    chk("t5b_best_valid", best_valid, 0);
    cyc(1, 1, 16'hF000, 11'd4, 1, 0);
    cyc(1, 1, 16'hE000, 11'd1199, 1, 0);
    chk("t5c_best_score", best_score, 16'hF000);
    chk("t5c_best_id", best_id, 4);
    chk("t5c_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'h2000, 11'(50 + i), 0, 0);
    chk("t6_level", level, 3);
    #2 rst = 0;
    #1;
    chk("t6_rst_o_valid", o_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_o_sw_id", o_sw_id, 0);
    chk("t6_rst_o_score", o_score, 0);
    chk("t6_rst_best_valid", best_valid, 0);
    chk("t6_rst_best_score", best_score, 0);
    reset_model();
    tick;
    rst = 1;
    cyc(1, 1, 16'h3000, 11'd10, 0, 0);
    cyc(1, 0, 16'h0000, 11'd1199, 0, 0);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_best_id", best_id, 10);
    chk("t6_best_score", best_score, 16'h3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
